satagtx_clk_seq: RTL and testbench

- Per-tile clock/reset bring-up sequencer for C_NUM_TILES SATA GTX/GTP tiles.
- Holds each tile's PLL and user-clock DCM/PLL in reset, then releases them in order and waits for PLL lock and user-clock lock.
- Qualifies lock stability, recovers from lock loss with bounded retries, and raises per-tile and global ready flags.
- Sits beside the tile clocking (IBUFDS/BUFG/DCM) logic, in the free-running system clock domain, driving the GTX and user-clock reset pins.

---
 rtl/satagtx_clk_seq.sv | 250 +++++++++++++++++++++++++
 tb/tb_satagtx_clk_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/satagtx_clk_seq.sv
// satagtx_clk_seq: per-tile clock/reset bring-up sequencer for SATA GTX/GTP tiles.
//
// Each tile holds its GTX PLL and user-clock DCM/PLL in reset, releases them in order,
// waits for both locks, qualifies them as stable and then raises tile_ready. A lock
// timeout or lock loss triggers a bounded number of retries before the tile latches
// tile_fail. A single-cycle restart pulse re-runs the sequence from the top.
//
// Optional build macro SATAGTX_LOCK_LOSS_CNT_EN adds the lock_loss_cnt output: one
// saturating 8-bit counter per tile that counts exits from the ready state caused by
// lock loss. It is cleared only by rst_n.

module satagtx_clk_seq #(
    parameter int unsigned C_NUM_TILES     = 2,
    parameter int unsigned C_RST_CYCLES    = 16,
    parameter int unsigned C_LOCK_TIMEOUT  = 65535,
    parameter int unsigned C_STABLE_CYCLES = 1024,
    parameter int unsigned C_MAX_RETRY     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [C_NUM_TILES-1:0]   pll_lock,
    input  logic [C_NUM_TILES-1:0]   dcm_lock,
    input  logic [C_NUM_TILES-1:0]   restart,
    output logic [C_NUM_TILES-1:0]   gtx_reset,
    output logic [C_NUM_TILES-1:0]   dcm_reset,
    output logic [C_NUM_TILES-1:0]   tile_ready,
    output logic [C_NUM_TILES-1:0]   tile_fail,
    output logic                     all_ready
`ifdef SATAGTX_LOCK_LOSS_CNT_EN
    ,
    output logic [8*C_NUM_TILES-1:0] lock_loss_cnt
`endif
);

    // Terminal counter values: a phase lasting N cycles ends when the counter reads N-1.
    localparam logic [15:0] RstLast    = 16'(C_RST_CYCLES - 1);
    localparam logic [15:0] TimeoutLast = 16'(C_LOCK_TIMEOUT - 1);
    localparam logic [15:0] StableLast = 16'(C_STABLE_CYCLES - 1);
    localparam logic [3:0]  MaxRetry   = 4'(C_MAX_RETRY);

    typedef enum logic [2:0] {
        StRst,
        StPll,
        StDcm,
        StStable,
        StReady,
        StFail
    } tile_state_e;

    logic [C_NUM_TILES-1:0] pll_meta;
    logic [C_NUM_TILES-1:0] pll_s;
    logic [C_NUM_TILES-1:0] dcm_meta;
    logic [C_NUM_TILES-1:0] dcm_s;
    logic                   all_ready_q;

    // Two-flop synchronisers for the asynchronous lock detects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pll_meta <= '0;
            pll_s    <= '0;
            dcm_meta <= '0;
            dcm_s    <= '0;
        end else begin
            pll_meta <= pll_lock;
            pll_s    <= pll_meta;
            dcm_meta <= dcm_lock;
            dcm_s    <= dcm_meta;
        end
    end

    for (genvar i = 0; i < C_NUM_TILES; i++) begin : g_tile
        tile_state_e state_q;
        tile_state_e state_d;
        logic [15:0] cnt_q;
        logic [15:0] cnt_d;
        logic [3:0]  retry_q;
        logic [3:0]  retry_d;
        logic        retry_evt;
        logic        gtx_rst_l;
        logic        dcm_rst_l;
        logic        ready_l;
        logic        fail_l;
        logic        locks_ok;

        assign locks_ok = pll_s[i] & dcm_s[i];

        // State register with the shared phase counter and retry count.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StRst;
                cnt_q   <= '0;
                retry_q <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                retry_q <= retry_d;
            end
        end

        // Next-state logic; restart overrides every lock, timeout and stable event.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            retry_d   = retry_q;
            retry_evt = 1'b0;
            if (restart[i]) begin
                state_d = StRst;
                cnt_d   = '0;
                retry_d = '0;
            end else begin
                unique case (state_q)
                    StRst: begin
                        if (cnt_q == RstLast) begin
                            state_d = StPll;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    StPll: begin
                        if (pll_s[i]) begin
                            state_d = StDcm;
                            cnt_d   = '0;
                        end else if (cnt_q == TimeoutLast) begin
                            retry_evt = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    StDcm: begin
                        if (!pll_s[i]) begin
                            retry_evt = 1'b1;
                        end else if (dcm_s[i]) begin
                            state_d = StStable;
                            cnt_d   = '0;
                        end else if (cnt_q == TimeoutLast) begin
                            retry_evt = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    StStable: begin
                        if (!locks_ok) begin
                            retry_evt = 1'b1;
                        end else if (cnt_q == StableLast) begin
                            state_d = StReady;
                            cnt_d   = '0;
                            retry_d = '0;
                        end else begin
                            cnt_d = cnt_q + 16'd1;
                        end
                    end
                    StReady: begin
                        if (!locks_ok) begin
                            retry_evt = 1'b1;
                        end
                    end
                    StFail: begin
                        cnt_d = '0;
                    end
                    default: begin
                        state_d = StRst;
                        cnt_d   = '0;
                    end
                endcase

                // Retry is a transition: either burn one retry or give up.
                if (retry_evt) begin
                    cnt_d = '0;
                    if (retry_q == MaxRetry) begin
                        state_d = StFail;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = StRst;
                    end
                end
            end
        end

        // Output decode straight from the state register so flags move with the state.
        always_comb begin
            gtx_rst_l = 1'b1;
            dcm_rst_l = 1'b1;
            ready_l   = 1'b0;
            fail_l    = 1'b0;
            unique case (state_q)
                StRst: begin
                    gtx_rst_l = 1'b1;
                    dcm_rst_l = 1'b1;
                end
                StPll: begin
                    gtx_rst_l = 1'b0;
                    dcm_rst_l = 1'b1;
                end
                StDcm, StStable: begin
                    gtx_rst_l = 1'b0;
                    dcm_rst_l = 1'b0;
                end
                StReady: begin
                    gtx_rst_l = 1'b0;
                    dcm_rst_l = 1'b0;
                    ready_l   = 1'b1;
                end
                StFail: begin
                    fail_l = 1'b1;
                end
                default: begin
                    gtx_rst_l = 1'b1;
                    dcm_rst_l = 1'b1;
                end
            endcase
        end

        assign gtx_reset[i]  = gtx_rst_l;
        assign dcm_reset[i]  = dcm_rst_l;
        assign tile_ready[i] = ready_l;
        assign tile_fail[i]  = fail_l;

`ifdef SATAGTX_LOCK_LOSS_CNT_EN
        logic [7:0] loss_q;
        logic       ready_exit;

        // Only a lock-loss exit from ready counts; a restart in the same cycle wins.
        assign ready_exit = (state_q == StReady) & ~restart[i] & ~locks_ok;

        // Saturating lock-loss counter, deliberately untouched by restart.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                loss_q <= '0;
            end else if (ready_exit && (loss_q != 8'hff)) begin
                loss_q <= loss_q + 8'd1;
            end
        end

        assign lock_loss_cnt[8*i +: 8] = loss_q;
`endif
    end

    // Global ready lags the per-tile flags by one cycle in both directions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            all_ready_q <= 1'b0;
        end else begin
            all_ready_q <= &tile_ready;
        end
    end

    assign all_ready = all_ready_q;

endmodule

// File: tb/tb_satagtx_clk_seq.sv
// Scoreboard bench for satagtx_clk_seq: a timestamp-based phase model predicts the
// outputs after each clock edge, a separate monitor pops and compares at the negedge.
module tb_satagtx_clk_seq;

    localparam int NT  = 2;
    localparam int RST = 4;
    localparam int TO  = 100;
    localparam int STB = 8;
    localparam int MR  = 2;

    localparam int P_RST  = 0;
    localparam int P_PLL  = 1;
    localparam int P_DCM  = 2;
    localparam int P_STB  = 3;
    localparam int P_RDY  = 4;
    localparam int P_FAIL = 5;

    logic          clk;
    logic          rst_n;
    logic [NT-1:0] pll_lock;
    logic [NT-1:0] dcm_lock;
    logic [NT-1:0] restart;
    logic [NT-1:0] gtx_reset;
    logic [NT-1:0] dcm_reset;
    logic [NT-1:0] tile_ready;
    logic [NT-1:0] tile_fail;
    logic          all_ready;
`ifdef SATAGTX_LOCK_LOSS_CNT_EN
    logic [8*NT-1:0] lock_loss_cnt;
`endif

    satagtx_clk_seq #(
        .C_NUM_TILES    (NT),
        .C_RST_CYCLES   (RST),
        .C_LOCK_TIMEOUT (TO),
        .C_STABLE_CYCLES(STB),
        .C_MAX_RETRY    (MR)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .dcm_lock  (dcm_lock),
        .restart   (restart),
        .gtx_reset (gtx_reset),
        .dcm_reset (dcm_reset),
        .tile_ready(tile_ready),
        .tile_fail (tile_fail),
        .all_ready (all_ready)
`ifdef SATAGTX_LOCK_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NT-1:0]   gtx;
        logic [NT-1:0]   dcm;
        logic [NT-1:0]   rdy;
        logic [NT-1:0]   fail;
        logic            all;
        logic [8*NT-1:0] llc;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;

    // Reference model: phase per tile plus the edge count at which it was entered.
    int            cyc;
    int            ph[NT];
    int            t0[NT];
    int            tries[NT];
    int            loss[NT];
    logic [NT-1:0] m_pll_m, m_pll_s, m_dcm_m, m_dcm_s;
    logic [NT-1:0] prev_rdy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
        end
    endtask

    task automatic model_init();
        cyc      = 0;
        m_pll_m  = '0;
        m_pll_s  = '0;
        m_dcm_m  = '0;
        m_dcm_s  = '0;
        prev_rdy = '0;
        for (int t = 0; t < NT; t++) begin
            ph[t]    = P_RST;
            t0[t]    = 0;
            tries[t] = 0;
            loss[t]  = 0;
        end
    endtask

    task automatic enter(input int t, input int p);
        ph[t] = p;
        t0[t] = cyc;
    endtask

    task automatic tile_step(input int t, input bit p, input bit d, input bit rs);
        int el;
        bit retry;
        el    = cyc - t0[t];
        retry = 0;
        if (rs) begin
            enter(t, P_RST);
            tries[t] = 0;
        end else begin
            case (ph[t])
                P_RST: if (el == RST) enter(t, P_PLL);
                P_PLL: begin
                    if (p) enter(t, P_DCM);
                    else if (el == TO) retry = 1;
                end
                P_DCM: begin
                    if (!p) retry = 1;
                    else if (d) enter(t, P_STB);
                    else if (el == TO) retry = 1;
                end
                P_STB: begin
                    if (!(p && d)) retry = 1;
                    else if (el == STB) begin
                        enter(t, P_RDY);
                        tries[t] = 0;
                    end
                end
                P_RDY: begin
                    if (!(p && d)) begin
                        retry = 1;
                        if (loss[t] < 255) loss[t]++;
                    end
                end
                default: ;
            endcase
            if (retry) begin
                if (tries[t] == MR) enter(t, P_FAIL);
                else begin
                    tries[t]++;
                    enter(t, P_RST);
                end
            end
        end
    endtask

    // Advance the model across one clock edge using the inputs the DUT sampled there.
    task automatic model_step();
        logic [NT-1:0] ps, ds;
        exp_t e;
        cyc++;
        ps      = m_pll_s;
        ds      = m_dcm_s;
        m_pll_s = m_pll_m;
        m_pll_m = pll_lock;
        m_dcm_s = m_dcm_m;
        m_dcm_m = dcm_lock;
        e.all   = &prev_rdy;
        for (int t = 0; t < NT; t++) begin
            tile_step(t, ps[t], ds[t], restart[t]);
            e.gtx[t]  = (ph[t] == P_RST) || (ph[t] == P_FAIL);
            e.dcm[t]  = (ph[t] == P_RST) || (ph[t] == P_PLL) || (ph[t] == P_FAIL);
            e.rdy[t]  = (ph[t] == P_RDY);
            e.fail[t] = (ph[t] == P_FAIL);
            e.llc[8*t +: 8] = 8'(loss[t]);
        end
        prev_rdy = e.rdy;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            model_step();
            #1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_gtx_reset", 32'(gtx_reset), 32'(2'b11));
        check("rst_dcm_reset", 32'(dcm_reset), 32'(2'b11));
        check("rst_tile_ready", 32'(tile_ready), 32'd0);
        check("rst_tile_fail", 32'(tile_fail), 32'd0);
        check("rst_all_ready", 32'(all_ready), 32'd0);
`ifdef SATAGTX_LOCK_LOSS_CNT_EN
        check("rst_lock_loss_cnt", 32'(lock_loss_cnt), 32'd0);
`endif
    endtask

    // Monitor: one prediction is consumed per cycle while enabled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (sb_q.size() == 0) begin
                    check("sb_underflow", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("gtx_reset", 32'(gtx_reset), 32'(e.gtx));
                    check("dcm_reset", 32'(dcm_reset), 32'(e.dcm));
                    check("tile_ready", 32'(tile_ready), 32'(e.rdy));
                    check("tile_fail", 32'(tile_fail), 32'(e.fail));
                    check("all_ready", 32'(all_ready), 32'(e.all));
`ifdef SATAGTX_LOCK_LOSS_CNT_EN
                    check("lock_loss_cnt", 32'(lock_loss_cnt), 32'(e.llc));
`endif
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        pll_lock = '0;
        dcm_lock = '0;
        restart  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        model_init();
        tick(1);
        mon_en = 1;

        // Bring-up of tile 0 while tile 1 stays unlocked and runs out of retries.
        tick(9);
        pll_lock[0] = 1'b1;
        tick(10);
        dcm_lock[0] = 1'b1;
        tick(340);

        // Restart tile 1 from fail on the same cycle its PLL lock rises.
        pll_lock[1] = 1'b1;
        restart[1]  = 1'b1;
        tick(1);
        restart[1]  = 1'b0;
        tick(3);
        dcm_lock[1] = 1'b1;
        tick(30);

        // Three one-cycle DCM lock losses on tile 1, then a restart.
        for (int n = 0; n < 3; n++) begin
            dcm_lock[1] = 1'b0;
            tick(1);
            dcm_lock[1] = 1'b1;
            tick(30);
        end
        restart[1] = 1'b1;
        tick(1);
        restart[1] = 1'b0;
        tick(30);

        // PLL glitch on tile 0 partway through stable qualification.
        restart[0] = 1'b1;
        tick(1);
        restart[0] = 1'b0;
        tick(9);
        pll_lock[0] = 1'b0;
        tick(1);
        pll_lock[0] = 1'b1;
        tick(40);

        // Asynchronous reset in mid-operation.
        @(negedge clk);
        #1;
        mon_en = 0;
        check("sb_drain_mid", 32'(sb_q.size()), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_init();
        tick(1);
        mon_en = 1;

        // Randomised lock activity with occasional glitches and restarts.
        for (int k = 0; k < 3000; k++) begin
            for (int t = 0; t < NT; t++) begin
                if ($urandom_range(0, 39) == 0) pll_lock[t] = ~pll_lock[t];
                if ($urandom_range(0, 29) == 0) dcm_lock[t] = ~dcm_lock[t];
                if ($urandom_range(0, 99) == 0) dcm_lock[t] = 1'b0;
                restart[t] = ($urandom_range(0, 299) == 0);
            end
            tick(1);
        end
        restart = '0;
        tick(5);

        @(negedge clk);
        #1;
        mon_en = 0;
        check("sb_drain_end", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
